stopwatch_timer: RTL and testbench

- Parametrised successor to the team's fixed seconds/tenths counter.
- Generalises clock rate, sub-second resolution and seconds range.
- Adds run/pause control, lap freeze, count-down mode with expiry, preset load and explicit wrap reporting.
- Sits between debounced push-button pulses and the 7-segment display formatter; the formatter reads disp_sec/disp_sub only.

---
 rtl/stopwatch_pkg.sv | 8 +
 rtl/stopwatch_timer_if.sv | 25 ++
 rtl/stopwatch_timer_prescaler.sv | 20 ++
 rtl/stopwatch_timer.sv | 121 ++++++++++++
 tb/tb_stopwatch_timer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, clock constant and prescaler divide helper
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
    localparam int DEFAULT_CLK_HZ = 5_000_000;
    function automatic int calc_div(input int clk_hz, input int ticks_per_sec);
        return clk_hz / ticks_per_sec;
    endfunction
endpackage

// File: rtl/stopwatch_timer_if.sv
// stopwatch_timer_if: button pulses and preset in, live/display counts and status out
interface stopwatch_timer_if #(parameter int SEC_W = 10, parameter int SUB_W = 4);
    logic             start_stop;
    logic             lap;
    logic             clear;
    logic             mode_down;
    logic             load;
    logic [SEC_W-1:0] load_sec;
    logic [SEC_W-1:0] sec;
    logic [SUB_W-1:0] sub;
    logic [SEC_W-1:0] disp_sec;
    logic [SUB_W-1:0] disp_sub;
    logic             running;
    logic             lap_hold;
    logic             wrap;
    logic             expired;
    modport master (
        output start_stop, lap, clear, mode_down, load, load_sec,
        input  sec, sub, disp_sec, disp_sub, running, lap_hold, wrap, expired
    );
    modport slave (
        input  start_stop, lap, clear, mode_down, load, load_sec,
        output sec, sub, disp_sec, disp_sub, running, lap_hold, wrap, expired
    );
endinterface

// File: rtl/stopwatch_timer_prescaler.sv
// tick_prescaler: divides clk by DIV while enabled, holding its partial count when disabled
module tick_prescaler #(parameter int DIV = 10) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && cnt_q == LAST;
        cnt_d = clr ? '0 : tick ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: run/pause stopwatch with lap freeze, count-down expiry, preset load and wrap pulse
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ        = DEFAULT_CLK_HZ,
    parameter int TICKS_PER_SEC = 10,
    parameter int SEC_MAX       = 999,
    parameter int SEC_W         = 10,
    parameter int SUB_W         = 4
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_timer_if.slave  bus
);
    localparam int DIV = calc_div(CLK_HZ, TICKS_PER_SEC);
    localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);
    localparam logic [SUB_W-1:0] SUB_TOP = SUB_W'(TICKS_PER_SEC - 1);
    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d, cap_sec_q, cap_sec_d, sec_nxt;
    logic [SUB_W-1:0] sub_q, sub_d, cap_sub_q, cap_sub_d, sub_nxt;
    logic             lap_hold_q, lap_hold_d, wrap_q, wrap_d, mode_q, mode_d;
    logic             tick, sub_end, step_wrap;
    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == RUN),
        .clr   (state_q == IDLE || bus.clear),
        .tick  (tick)
    );
    // Value the live count takes on a tick, in the latched direction
    always_comb begin
        sub_end   = sub_q == SUB_TOP;
        step_wrap = !mode_q && sub_end && sec_q == SEC_TOP;
        sub_nxt   = mode_q ? (sub_q == '0 ? SUB_TOP : sub_q - 1'b1)
                           : (sub_end ? '0 : sub_q + 1'b1);
        sec_nxt   = mode_q ? (sub_q == '0 ? sec_q - 1'b1 : sec_q)
                           : (sub_end ? (step_wrap ? '0 : sec_q + 1'b1) : sec_q);
    end
    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        sub_d      = sub_q;
        cap_sec_d  = cap_sec_q;
        cap_sub_d  = cap_sub_q;
        lap_hold_d = lap_hold_q;
        mode_d     = mode_q;
        wrap_d     = 1'b0;
        if (bus.clear) begin
            state_d    = IDLE;
            sec_d      = '0;
            sub_d      = '0;
            lap_hold_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        sec_d = bus.load_sec > SEC_TOP ? SEC_TOP : bus.load_sec;
                        sub_d = '0;
                    end else if (bus.start_stop && !(bus.mode_down && sec_q == '0 && sub_q == '0)) begin
                        state_d = RUN;
                        mode_d  = bus.mode_down;
                    end
                end
                RUN: begin
                    if (tick) begin
                        sec_d  = sec_nxt;
                        sub_d  = sub_nxt;
                        wrap_d = step_wrap;
                    end
                    // A tick reaching 0.0 in down mode expires even if start_stop arrives alongside
                    if (tick && mode_q && sec_nxt == '0 && sub_nxt == '0) begin
                        state_d    = EXPIRED;
                        lap_hold_d = 1'b0;
                    end else if (bus.start_stop) begin
                        state_d = PAUSE;
                    end else if (bus.lap) begin
                        lap_hold_d = !lap_hold_q;
                        if (!lap_hold_q) begin
                            cap_sec_d = sec_q;
                            cap_sub_d = sub_q;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.start_stop) state_d = RUN;
                    else if (bus.lap)   lap_hold_d = 1'b0;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            sub_q      <= '0;
            cap_sec_q  <= '0;
            cap_sub_q  <= '0;
            lap_hold_q <= 1'b0;
            wrap_q     <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            sub_q      <= sub_d;
            cap_sec_q  <= cap_sec_d;
            cap_sub_q  <= cap_sub_d;
            lap_hold_q <= lap_hold_d;
            wrap_q     <= wrap_d;
            mode_q     <= mode_d;
        end
    end
    assign bus.sec      = sec_q;
    assign bus.sub      = sub_q;
    assign bus.disp_sec = lap_hold_q ? cap_sec_q : sec_q;
    assign bus.disp_sub = lap_hold_q ? cap_sub_q : sub_q;
    assign bus.running  = state_q == RUN;
    assign bus.lap_hold = lap_hold_q;
    assign bus.wrap     = wrap_q;
    assign bus.expired  = state_q == EXPIRED;
endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: directed scoreboard bench at 100 Hz clock, tenths, 0..5 s range
module tb_stopwatch_timer;
    localparam int SEC_W = 3;
    localparam int SUB_W = 4;
    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    stopwatch_timer_if #(.SEC_W(SEC_W), .SUB_W(SUB_W)) sw();
    stopwatch_timer #(
        .CLK_HZ(100), .TICKS_PER_SEC(10), .SEC_MAX(5), .SEC_W(SEC_W), .SUB_W(SUB_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw)
    );
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic drive(input logic ss, input logic lp, input logic cl, input logic ld);
        sw.start_stop = ss;
        sw.lap        = lp;
        sw.clear      = cl;
        sw.load       = ld;
        @(negedge clk);
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
        sw.load       = 1'b0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic expect_v(input string t, input logic [31:0] v);
        sb.push_back('{tag: t, val: v});
    endtask
    task automatic got(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask
    task automatic expect_zero(input string p);
        expect_v({p, "_sec"}, 0);
        expect_v({p, "_sub"}, 0);
        expect_v({p, "_disp_sec"}, 0);
        expect_v({p, "_disp_sub"}, 0);
        expect_v({p, "_running"}, 0);
        expect_v({p, "_lap_hold"}, 0);
        expect_v({p, "_wrap"}, 0);
        expect_v({p, "_expired"}, 0);
    endtask
    task automatic got_all();
        got(sw.sec);
        got(sw.sub);
        got(sw.disp_sec);
        got(sw.disp_sub);
        got(sw.running);
        got(sw.lap_hold);
        got(sw.wrap);
        got(sw.expired);
    endtask
    initial begin
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
        sw.mode_down  = 1'b0;
        sw.load       = 1'b0;
        sw.load_sec   = '0;
        // Reset state, then first increment exactly 10 clocks after start
        do_reset();
        expect_zero("rst0");
        got_all();
        drive(1, 0, 0, 0);
        expect_v("t1_sub_at9", 0);
        cyc(9); got(sw.sub);
        expect_v("t1_sub_at10", 1);
        cyc(1); got(sw.sub);
        expect_v("t1_sec", 1); expect_v("t1_sub", 0); expect_v("t1_running", 1);
        cyc(90); got(sw.sec); got(sw.sub); got(sw.running);
        // Pause keeps the partial prescaler count
        do_reset();
        drive(1, 0, 0, 0);
        expect_v("t2_sub_run", 3);
        cyc(35); got(sw.sub);
        expect_v("t2_paused", 0);
        drive(1, 0, 0, 0); got(sw.running);
        expect_v("t2_sub_paused", 3);
        cyc(49); got(sw.sub);
        drive(1, 0, 0, 0);
        expect_v("t2_sec", 0); expect_v("t2_sub", 6); expect_v("t2_running", 1);
        cyc(25); got(sw.sec); got(sw.sub); got(sw.running);
        // Up-count wrap 5.9 -> 0.0 with a single-cycle pulse
        do_reset();
        drive(1, 0, 0, 0);
        expect_v("t3_pre_sec", 5); expect_v("t3_pre_sub", 9); expect_v("t3_pre_wrap", 0);
        cyc(599); got(sw.sec); got(sw.sub); got(sw.wrap);
        expect_v("t3_wrap", 1); expect_v("t3_sec", 0); expect_v("t3_sub", 0); expect_v("t3_running", 1);
        cyc(1); got(sw.wrap); got(sw.sec); got(sw.sub); got(sw.running);
        expect_v("t3_post_wrap", 0);
        cyc(1); got(sw.wrap);
        // Count-down from a preset to expiry
        do_reset();
        sw.mode_down = 1'b1;
        sw.load_sec  = 3'd0;
        drive(0, 0, 0, 1);
        expect_v("t4_zero_start_ignored", 0);
        drive(1, 0, 0, 0); got(sw.running);
        sw.load_sec = 3'd2;
        expect_v("t4_load_sec", 2); expect_v("t4_load_sub", 0);
        drive(0, 0, 0, 1); got(sw.sec); got(sw.sub);
        drive(1, 0, 0, 0);
        expect_v("t4_first_sec", 1); expect_v("t4_first_sub", 9);
        cyc(10); got(sw.sec); got(sw.sub);
        expect_v("t4_expired", 1); expect_v("t4_running", 0); expect_v("t4_sec", 0); expect_v("t4_sub", 0);
        cyc(190); got(sw.expired); got(sw.running); got(sw.sec); got(sw.sub);
        expect_v("t4_start_ignored", 1);
        drive(1, 0, 0, 0); got(sw.expired);
        expect_v("t4_clear_expired", 0); expect_v("t4_clear_running", 0);
        drive(0, 0, 1, 0); got(sw.expired); got(sw.running);
        sw.mode_down = 1'b0;
        // Lap freeze and release, then lap in pause
        do_reset();
        drive(1, 0, 0, 0);
        expect_v("t5_sub_before", 3);
        cyc(30); got(sw.sub);
        expect_v("t5_hold", 1); expect_v("t5_disp_cap", 3);
        drive(0, 1, 0, 0); got(sw.lap_hold); got(sw.disp_sub);
        expect_v("t5_disp_sec", 0); expect_v("t5_disp_sub", 3); expect_v("t5_sec", 0); expect_v("t5_sub", 7);
        cyc(39); got(sw.disp_sec); got(sw.disp_sub); got(sw.sec); got(sw.sub);
        expect_v("t5_release", 0); expect_v("t5_disp_live", 7);
        drive(0, 1, 0, 0); got(sw.lap_hold); got(sw.disp_sub);
        drive(0, 1, 0, 0);
        expect_v("t5_pause_hold", 1); expect_v("t5_pause_running", 0);
        drive(1, 0, 0, 0); got(sw.lap_hold); got(sw.running);
        expect_v("t5_pause_lap", 0);
        drive(0, 1, 0, 0); got(sw.lap_hold);
        // Reset/clear priority, load ignored in RUN, load clamp
        do_reset();
        drive(1, 0, 0, 0);
        expect_v("t6_sec", 1); expect_v("t6_sub", 4);
        cyc(140); got(sw.sec); got(sw.sub);
        reset = 1'b1;
        sw.clear = 1'b1;
        sw.start_stop = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sw.clear = 1'b0;
        sw.start_stop = 1'b0;
        expect_zero("t6_rst");
        got_all();
        drive(1, 0, 0, 0);
        cyc(20);
        expect_v("t6_clr_running", 0); expect_v("t6_clr_sec", 0); expect_v("t6_clr_sub", 0);
        drive(1, 0, 1, 0); got(sw.running); got(sw.sec); got(sw.sub);
        drive(1, 0, 0, 0);
        cyc(15);
        sw.load_sec = 3'd3;
        expect_v("t6_run_load_sec", 0); expect_v("t6_run_load_sub", 1); expect_v("t6_run_load_running", 1);
        drive(0, 0, 0, 1); got(sw.sec); got(sw.sub); got(sw.running);
        drive(0, 0, 1, 0);
        sw.load_sec = 3'd7;
        expect_v("t6_clamp_sec", 5); expect_v("t6_clamp_sub", 0);
        drive(0, 0, 0, 1); got(sw.sec); got(sw.sub);
        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
